// File: rtl/cache_pkg.sv
// Shared types for the cache line-state store.
//   flush_state_e : flush engine states
//   line_state_t  : per-line metadata {valid, dirty}
//   idx_width()   : index width for a count, never below 1 bit
package cache_pkg;

   typedef enum logic [1:0] {
      FL_IDLE = 2'd0,
      FL_SCAN = 2'd1,
      FL_WB   = 2'd2,
      FL_DONE = 2'd3
   } flush_state_e;

   typedef struct packed {
      logic valid;
      logic dirty;
   } line_state_t;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/line_state_array_flush_sequencer.sv
// Flush engine: walks every line in {set, way} order (way in the low bits),
// requests a write-back for each valid+dirty line and optionally invalidates.
//
// state   | meaning
// --------+------------------------------------------------------------
// FL_IDLE | waiting for flush_req_i; access port owns the array
// FL_SCAN | examining the line at the current index, one per cycle
// FL_WB   | wb_valid_o high for the current index until wb_ready_i
// FL_DONE | flush_done_o pulse, back to idle next cycle
//
// Ports:
//   flush_req_i/flush_invalidate_i : start request and captured mode
//   line_valid_i/line_dirty_i      : metadata of the line at idx_set_o/idx_way_o
//   clr_valid_o/clr_dirty_o        : clear strobes for that line
//   wb_valid_o/wb_ready_i          : write-back handshake (address = idx_*_o)
//   flush_busy_o/flush_done_o      : status
module flush_sequencer
   import cache_pkg::*;
#(
   parameter int unsigned NUM_SETS = 16,
   parameter int unsigned NUM_WAYS = 2,
   parameter int unsigned SET_W    = idx_width(NUM_SETS),
   parameter int unsigned WAY_W    = idx_width(NUM_WAYS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_req_i,
   input  logic             flush_invalidate_i,
   input  logic             line_valid_i,
   input  logic             line_dirty_i,
   input  logic             wb_ready_i,
   output logic [SET_W-1:0] idx_set_o,
   output logic [WAY_W-1:0] idx_way_o,
   output logic             clr_valid_o,
   output logic             clr_dirty_o,
   output logic             wb_valid_o,
   output logic             flush_busy_o,
   output logic             flush_done_o
);

   localparam logic [SET_W-1:0] LAST_SET = SET_W'(NUM_SETS - 1);
   localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

   flush_state_e     state_q, state_d;
   logic [SET_W-1:0] set_q, set_d;
   logic [WAY_W-1:0] way_q, way_d;
   logic             inv_q, inv_d;
   logic             advance;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FL_IDLE;
         set_q   <= '0;
         way_q   <= '0;
         inv_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         set_q   <= set_d;
         way_q   <= way_d;
         inv_q   <= inv_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      set_d        = set_q;
      way_d        = way_q;
      inv_d        = inv_q;
      advance      = 1'b0;
      clr_valid_o  = 1'b0;
      clr_dirty_o  = 1'b0;
      wb_valid_o   = 1'b0;
      flush_done_o = 1'b0;

      case (state_q)
         FL_IDLE: begin
            if (flush_req_i) begin
               inv_d   = flush_invalidate_i;
               set_d   = '0;
               way_d   = '0;
               state_d = FL_SCAN;
            end
         end
         FL_SCAN: begin
            if (line_valid_i && line_dirty_i) begin
               state_d = FL_WB;
            end else begin
               clr_valid_o = inv_q;
               advance     = 1'b1;
            end
         end
         FL_WB: begin
            wb_valid_o = 1'b1;
            if (wb_ready_i) begin
               clr_dirty_o = 1'b1;
               clr_valid_o = inv_q;
               advance     = 1'b1;
               state_d     = FL_SCAN;
            end
         end
         FL_DONE: begin
            flush_done_o = 1'b1;
            state_d      = FL_IDLE;
         end
         default: state_d = FL_IDLE;
      endcase

      // Way is stepped separately so an unused way bit (NUM_WAYS = 1) stays 0;
      // the last line is found by compare, never by counter overflow.
      if (advance) begin
         if (set_q == LAST_SET && way_q == LAST_WAY) begin
            state_d = FL_DONE;
         end else if (way_q == LAST_WAY) begin
            way_d = '0;
            set_d = set_q + 1'b1;
         end else begin
            way_d = way_q + 1'b1;
         end
      end
   end

   assign idx_set_o    = set_q;
   assign idx_way_o    = way_q;
   assign flush_busy_o = (state_q != FL_IDLE);

endmodule

// File: rtl/line_state_array.sv
// Per-set, per-way valid/dirty store for the set-associative data cache,
// with a flush engine that hands dirty lines to the write-back unit.
//
// Ports:
//   access_set/access_way + set_valid/clear_valid/set_dirty/clear_dirty :
//       single-line update port, ignored while flush_busy
//   sel_valid/sel_dirty, set_valid_mask/set_dirty_mask : combinational reads
//   flush_req/flush_invalidate, flush_busy/flush_done  : flush control
//   wb_valid/wb_set/wb_way/wb_ready                    : write-back handshake
module line_state_array
   import cache_pkg::*;
#(
   parameter int unsigned NUM_SETS = 16,
   parameter int unsigned NUM_WAYS = 2,
   localparam int unsigned SET_W   = idx_width(NUM_SETS),
   localparam int unsigned WAY_W   = idx_width(NUM_WAYS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [SET_W-1:0]    access_set,
   input  logic [WAY_W-1:0]    access_way,
   input  logic                set_valid,
   input  logic                clear_valid,
   input  logic                set_dirty,
   input  logic                clear_dirty,
   output logic                sel_valid,
   output logic                sel_dirty,
   output logic [NUM_WAYS-1:0] set_valid_mask,
   output logic [NUM_WAYS-1:0] set_dirty_mask,
   input  logic                flush_req,
   input  logic                flush_invalidate,
   output logic                flush_busy,
   output logic                flush_done,
   output logic                wb_valid,
   output logic [SET_W-1:0]    wb_set,
   output logic [WAY_W-1:0]    wb_way,
   input  logic                wb_ready
);

   line_state_t      lines_q [NUM_SETS][NUM_WAYS];
   line_state_t      lines_d [NUM_SETS][NUM_WAYS];
   logic [SET_W-1:0] acc_set;
   logic [WAY_W-1:0] acc_way;
   logic [SET_W-1:0] seq_set;
   logic [WAY_W-1:0] seq_way;
   logic             seq_clr_valid;
   logic             seq_clr_dirty;

   // Degenerate single-set / single-way configs still carry a 1-bit index.
   assign acc_set = (NUM_SETS > 1) ? access_set : '0;
   assign acc_way = (NUM_WAYS > 1) ? access_way : '0;

   flush_sequencer #(
      .NUM_SETS (NUM_SETS),
      .NUM_WAYS (NUM_WAYS),
      .SET_W    (SET_W),
      .WAY_W    (WAY_W)
   ) u_flush_sequencer (
      .clk                (clk),
      .rst_n              (rst_n),
      .flush_req_i        (flush_req),
      .flush_invalidate_i (flush_invalidate),
      .line_valid_i       (lines_q[seq_set][seq_way].valid),
      .line_dirty_i       (lines_q[seq_set][seq_way].dirty),
      .wb_ready_i         (wb_ready),
      .idx_set_o          (seq_set),
      .idx_way_o          (seq_way),
      .clr_valid_o        (seq_clr_valid),
      .clr_dirty_o        (seq_clr_dirty),
      .wb_valid_o         (wb_valid),
      .flush_busy_o       (flush_busy),
      .flush_done_o       (flush_done)
   );

   assign wb_set = seq_set;
   assign wb_way = seq_way;

   always_comb begin
      lines_d = lines_q;
      // Access port and flush engine never act in the same cycle: the port
      // is locked out whenever the engine is out of idle.
      if (!flush_busy) begin
         if (clear_valid) begin
            lines_d[acc_set][acc_way] = '0;
         end else begin
            if (set_valid || set_dirty) lines_d[acc_set][acc_way].valid = 1'b1;
            if (clear_dirty)            lines_d[acc_set][acc_way].dirty = 1'b0;
            else if (set_dirty)         lines_d[acc_set][acc_way].dirty = 1'b1;
         end
      end
      if (seq_clr_valid) lines_d[seq_set][seq_way]       = '0;
      if (seq_clr_dirty) lines_d[seq_set][seq_way].dirty = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lines_q <= '{default: '0};
      else        lines_q <= lines_d;
   end

   assign sel_valid = lines_q[acc_set][acc_way].valid;
   assign sel_dirty = lines_q[acc_set][acc_way].dirty;

   always_comb begin
      set_valid_mask = '0;
      set_dirty_mask = '0;
      for (int w = 0; w < NUM_WAYS; w++) begin
         set_valid_mask[w] = lines_q[acc_set][w].valid;
         set_dirty_mask[w] = lines_q[acc_set][w].dirty;
      end
   end

endmodule

// File: tb/tb_line_state_array.sv
module tb_line_state_array;

   localparam int NS = 16;
   localparam int NW = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] access_set;
   logic [0:0] access_way;
   logic       set_valid, clear_valid, set_dirty, clear_dirty;
   logic       sel_valid, sel_dirty;
   logic [1:0] set_valid_mask, set_dirty_mask;
   logic       flush_req, flush_invalidate, flush_busy, flush_done;
   logic       wb_valid, wb_ready;
   logic [3:0] wb_set;
   logic [0:0] wb_way;

   int errors = 0;
   int checks = 0;
   bit mv[NS][NW];
   bit md[NS][NW];

   line_state_array #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .access_set       (access_set),
      .access_way       (access_way),
      .set_valid        (set_valid),
      .clear_valid      (clear_valid),
      .set_dirty        (set_dirty),
      .clear_dirty      (clear_dirty),
      .sel_valid        (sel_valid),
      .sel_dirty        (sel_dirty),
      .set_valid_mask   (set_valid_mask),
      .set_dirty_mask   (set_dirty_mask),
      .flush_req        (flush_req),
      .flush_invalidate (flush_invalidate),
      .flush_busy       (flush_busy),
      .flush_done       (flush_done),
      .wb_valid         (wb_valid),
      .wb_set           (wb_set),
      .wb_way           (wb_way),
      .wb_ready         (wb_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: the access rules in plain form (dirty implies valid).
   task automatic model_access(input int s, input int w, input bit sv, input bit cv,
                               input bit sd, input bit cd);
      if (cv) begin
         mv[s][w] = 0;
         md[s][w] = 0;
      end else begin
         if (sv || sd) mv[s][w] = 1;
         if (cd)       md[s][w] = 0;
         else if (sd)  md[s][w] = 1;
      end
   endtask

   task automatic drive_access(input int s, input int w, input bit sv, input bit cv,
                               input bit sd, input bit cd);
      access_set = 4'(s);
      access_way = 1'(w);
      {set_valid, clear_valid, set_dirty, clear_dirty} = {sv, cv, sd, cd};
      model_access(s, w, sv, cv, sd, cd);
      tick();
      {set_valid, clear_valid, set_dirty, clear_dirty} = 4'b0;
   endtask

   task automatic check_line(input string tag, input int s, input int w);
      access_set = 4'(s);
      access_way = 1'(w);
      #1;
      chk({tag, "_sel_valid"}, 32'(sel_valid), 32'(mv[s][w]));
      chk({tag, "_sel_dirty"}, 32'(sel_dirty), 32'(md[s][w]));
      chk({tag, "_vmask"}, 32'(set_valid_mask), 32'({mv[s][1], mv[s][0]}));
      chk({tag, "_dmask"}, 32'(set_dirty_mask), 32'({md[s][1], md[s][0]}));
   endtask

   task automatic check_all(input string tag);
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++)
            check_line(tag, s, w);
   endtask

   // Runs one flush. Expected write-back order is line order {set, way};
   // expected busy length = lines + 1 (DONE) + dirty lines + stall cycles.
   task automatic run_flush(input string tag, input bit inv, input int first_delay,
                            input bit rand_delay);
      int exp_s[$];
      int exp_w[$];
      int nexp, busy, done_cnt, done_at, wbs, guard, delay, stall;
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++)
            if (md[s][w]) begin
               exp_s.push_back(s);
               exp_w.push_back(w);
            end
      nexp = exp_s.size();
      busy = 0; done_cnt = 0; done_at = -1; wbs = 0; guard = 0; stall = 0;
      delay = first_delay;
      flush_invalidate = inv;
      flush_req = 1'b1;
      wb_ready = 1'b1;
      tick();
      flush_req = 1'b0;
      flush_invalidate = 1'b0;
      while (flush_busy === 1'b1 && guard < 2000) begin
         guard++;
         busy++;
         if (flush_done === 1'b1) begin
            done_cnt++;
            done_at = busy;
         end
         // Update strobes while busy must be ignored by the array.
         access_set = 4'($urandom_range(0, NS - 1));
         access_way = 1'($urandom_range(0, NW - 1));
         {set_valid, clear_valid, set_dirty, clear_dirty} = 4'($urandom);
         if (wb_valid === 1'b1) begin
            if (exp_s.size() > 0) begin
               chk({tag, "_wb_set"}, 32'(wb_set), 32'(exp_s[0]));
               chk({tag, "_wb_way"}, 32'(wb_way), 32'(exp_w[0]));
            end
            if (delay > 0) begin
               wb_ready = 1'b0;
               delay--;
               stall++;
            end else begin
               wb_ready = 1'b1;
               wbs++;
               if (exp_s.size() > 0) begin
                  void'(exp_s.pop_front());
                  void'(exp_w.pop_front());
               end
               delay = rand_delay ? int'($urandom_range(0, 3)) : 0;
            end
         end else begin
            wb_ready = 1'($urandom_range(0, 1));
         end
         tick();
      end
      {set_valid, clear_valid, set_dirty, clear_dirty} = 4'b0;
      wb_ready = 1'b1;
      chk({tag, "_busy_cycles"}, 32'(busy), 32'(NS * NW + 1 + nexp + stall));
      chk({tag, "_done_count"}, 32'(done_cnt), 32'd1);
      chk({tag, "_done_pos"}, 32'(done_at), 32'(NS * NW + 1 + nexp + stall));
      chk({tag, "_wb_count"}, 32'(wbs), 32'(nexp));
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++) begin
            md[s][w] = 0;
            if (inv) mv[s][w] = 0;
         end
   endtask

   initial begin
      int g;
      rst_n = 1'b0;
      access_set = '0; access_way = '0;
      {set_valid, clear_valid, set_dirty, clear_dirty} = 4'b0;
      flush_req = 1'b0; flush_invalidate = 1'b0; wb_ready = 1'b1;
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++) begin
            mv[s][w] = 0;
            md[s][w] = 0;
         end
      #12;
      chk("rst_busy", 32'(flush_busy), 32'd0);
      chk("rst_done", 32'(flush_done), 32'd0);
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_wb_set", 32'(wb_set), 32'd0);
      chk("rst_wb_way", 32'(wb_way), 32'd0);
      rst_n = 1'b1;
      tick();

      // 1: everything clear after reset
      check_all("t1");

      // 2: clear_dirty beats set_dirty; valid stays
      drive_access(5, 1, 0, 0, 1, 0);
      drive_access(5, 1, 0, 0, 1, 1);
      check_line("t2", 5, 1);
      chk("t2_vmask_lit", 32'(set_valid_mask), 32'b10);
      chk("t2_dmask_lit", 32'(set_dirty_mask), 32'b00);

      // 3: two dirty lines, no invalidate, ready always high
      drive_access(3, 0, 0, 0, 1, 0);
      drive_access(15, 1, 0, 0, 1, 0);
      run_flush("t3", 0, 0, 0);
      check_all("t3_post");

      // 4: first write-back stalled 4 cycles
      drive_access(3, 0, 0, 0, 1, 0);
      drive_access(15, 1, 0, 0, 1, 0);
      run_flush("t4", 0, 4, 0);
      check_all("t4_post");

      // 5: invalidate flush over all-valid, all-clean lines
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++)
            drive_access(s, w, 1, 0, 0, 0);
      run_flush("t5", 1, 0, 0);
      check_all("t5_post");

      // Random access traffic against the model
      for (int i = 0; i < 300; i++) begin
         int s, w;
         bit [3:0] st;
         s = $urandom_range(0, NS - 1);
         w = $urandom_range(0, NW - 1);
         st = 4'($urandom);
         drive_access(s, w, st[3], st[2] & ($urandom_range(0, 3) == 0), st[1], st[0]);
         check_line("rnd_acc", s, w);
         check_line("rnd_any", $urandom_range(0, NS - 1), $urandom_range(0, NW - 1));
      end

      // Random flushes with random stalls
      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 12; i++)
            drive_access($urandom_range(0, NS - 1), $urandom_range(0, NW - 1),
                         1'($urandom), 1'b0, 1'($urandom), 1'b0);
         run_flush("rnd_fl", 1'($urandom), $urandom_range(0, 3), 1);
         check_all("rnd_fl_post");
      end

      // 6: reset while waiting in write-back
      drive_access(3, 0, 0, 0, 1, 0);
      wb_ready = 1'b0;
      flush_req = 1'b1;
      tick();
      flush_req = 1'b0;
      g = 0;
      while (wb_valid !== 1'b1 && g < 100) begin
         g++;
         tick();
      end
      chk("t6_reach_wb", 32'(wb_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_wb_drop", 32'(wb_valid), 32'd0);
      chk("t6_busy_drop", 32'(flush_busy), 32'd0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("t6_no_done", 32'(flush_done), 32'd0);
      end
      for (int s = 0; s < NS; s++)
         for (int w = 0; w < NW; w++) begin
            mv[s][w] = 0;
            md[s][w] = 0;
         end
      rst_n = 1'b1;
      wb_ready = 1'b1;
      tick();
      check_all("t6_post_rst");
      run_flush("t6_new", 0, 0, 0);
      drive_access(7, 0, 0, 0, 1, 0);
      run_flush("t6_new_dirty", 0, 1, 0);
      check_all("t6_end");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
